regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised general-purpose register file for the multicycle processor datapath.
- Replaces the per-register instances with a single array.
- Two registered read ports (the A/B operand latches) and one clocked write port.
- Optional hard-wired zero register and a sequenced bulk-clear engine for software/debug reset of the architectural state.

Parameters:
- DATA_W, 32: register and data-path width in bits.
- ADDR_W, 5: register-address width.
- NUM_REGS, 32: number of implemented registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- ZERO_REG, 1: 1 makes register 0 read as zero and ignore writes; 0 makes register 0 an ordinary register.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rs  in  ADDR_W  read address, port A.
- rt  in  ADDR_W  read address, port B.
- rd  in  ADDR_W  write address.
- we  in  1  write enable.
- i_data  in  DATA_W  write data.
- rd_en  in  1  load both output latches this cycle.
- clr_req  in  1  start a bulk clear (single-cycle pulse or level).
- out_data_a  out  DATA_W  latched port-A read data.
- out_data_b  out  DATA_W  latched port-B read data.
- busy  out  1  high while a bulk clear is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers = 0, out_data_a = out_data_b = 0, busy = 0.
  - FSM = IDLE, clear counter = 0.
  - Reset dominates everything, including a clear in progress, which is abandoned.
- Write:
  - At a rising edge with we=1 and busy=0, reg[rd] <= i_data.
  - Dropped if rd >= NUM_REGS.
  - Dropped if ZERO_REG=1 and rd=0.
- Read:
  - At a rising edge with rd_en=1 and busy=0, out_data_a <= reg[rs] and out_data_b <= reg[rt].
  - One-cycle latency from address to output.
  - Outputs hold their value whenever rd_en=0 or busy=1.
  - Address >= NUM_REGS reads 0.
  - With ZERO_REG=1, address 0 reads 0.
- Same-edge write and read of the same register: without the optional feature, the read latches the pre-write value.
- FSM:
  - IDLE: clr_req=1 -> CLEAR, counter = 0, busy = 1 from the next cycle.
  - CLEAR: one register per cycle, reg[counter] <= 0, counter increments.
  - CLEAR exits to IDLE after the cycle that clears NUM_REGS-1; busy falls the same edge.
  - A clear therefore takes exactly NUM_REGS cycles with busy high.
  - clr_req while busy is ignored; it is not queued.
  - we and rd_en while busy are ignored (write lost, outputs hold).
- Simultaneous events in IDLE: clr_req with we=1 in the same cycle:
  - The write is performed on that edge.
  - The clear starts the next cycle and overwrites it.
  - rd_en in the same cycle is honoured.
- Counter width: ADDR_W+1 bits so NUM_REGS = 2**ADDR_W terminates without wrap ambiguity.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: on an edge with rd_en=1 and a valid write (accepted per the write rules), any read port whose address equals rd latches i_data instead of the stale value.
  - Bypass never applies to a dropped write (rd=0 with ZERO_REG=1, or rd out of range).
- Undefined: no bypass; the read latches the pre-write value.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_REGS constants;
  - FSM state typedef (IDLE, CLEAR);
  - REG_ZERO index constant.
- One natural sub-module: regfile_clear_seq, containing the FSM, counter and busy, and emitting the clear address and clear strobe to the array.

Test Plan:
- Reset, then rd_en=1, rs=3, rt=4 -> out_data_a=0, out_data_b=0 one cycle later; busy=0.
- Write rd=5, i_data=0xDEADBEEF, we=1; next cycle rd_en=1, rs=5, rt=0 (ZERO_REG=1) -> out_data_a=0xDEADBEEF, out_data_b=0. A write to rd=0 of 0x1234 followed by a read of rs=0 -> 0.
- Same-edge we=1, rd=7, i_data=0xA5A5A5A5, rd_en=1, rs=7, with reg[7] previously 0x11 -> out_data_a=0x11 without the macro, 0xA5A5A5A5 with REGFILE_WRITE_BYPASS_EN.
- Fill regs 1..31 with their index, pulse clr_req:
  - busy is high for exactly 32 cycles;
  - we=1, rd=9, i_data=0xFF mid-clear is ignored;
  - afterwards every register reads 0.
- During a clear, assert rst_n=0 asynchronously mid-cycle -> busy=0 and outputs=0 immediately; after release, rd_en reads 0 everywhere.
- NUM_REGS=16, ADDR_W=5: a write to rd=20 is dropped and a read of rs=20 returns 0; a clear lasts 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_NUM_REGS = 32;

   // Index of the optional hard-wired zero register.
   localparam int REG_ZERO = 0;

   // Bulk-clear sequencer states.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks the register indices 0..NUM_REGS-1, one per
// cycle, strobing the array with a clear address while busy is high.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_en,
   output logic [ADDR_W:0]   clr_addr
);

   // One extra counter bit so NUM_REGS == 2**ADDR_W ends without wrapping.
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);

   clr_state_e        state;
   logic [ADDR_W:0]   cnt;

   // FSM, counter and registered busy; requests while clearing are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clr_req) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (cnt == LAST) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_en   = (state == ST_CLEAR);
   assign clr_addr = cnt;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two latched read ports, one write port,
// optional zero register and a sequenced bulk clear.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward same-edge
// accepted write data into the read latches.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic              we,
   input  logic [DATA_W-1:0] i_data,
   input  logic              rd_en,
   input  logic              clr_req,
   output logic [DATA_W-1:0] out_data_a,
   output logic [DATA_W-1:0] out_data_b,
   output logic              busy
);

   // The read mux spans the full address space; unimplemented slots and the
   // zero register are constant zero so out-of-range reads need no extra logic.
   localparam int               DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0]  NREGS    = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   logic                clr_en;
   logic [ADDR_W:0]     clr_addr;
   logic                wr_ok;
   logic [DATA_W-1:0]   rdata [DEPTH];
   logic [DATA_W-1:0]   rd_a;
   logic [DATA_W-1:0]   rd_b;

   regfile_clear_seq #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_clr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   // A write is accepted only when idle, in range and not aimed at the zero register.
   assign wr_ok = we && !busy && ({1'b0, rd} < NREGS) &&
                  !((ZERO_REG != 0) && (rd == ZERO_IDX));

   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
      if ((g >= NUM_REGS) || ((ZERO_REG != 0) && (g == REG_ZERO))) begin : g_const
         assign rdata[g] = '0;
      end else begin : g_store
         logic [DATA_W-1:0] q;
         // Storage cell: clear strobe first, then accepted write.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               q <= '0;
            else if (clr_en && (clr_addr == {1'b0, IDX}))
               q <= '0;
            else if (wr_ok && (rd == IDX))
               q <= i_data;
         end
         assign rdata[g] = q;
      end
   end

   // Read data ahead of the output latches, with optional write forwarding.
   always_comb begin
      rd_a = rdata[rs];
      rd_b = rdata[rt];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_ok && (rs == rd)) rd_a = i_data;
      if (wr_ok && (rt == rd)) rd_b = i_data;
`endif
   end

   // Operand latches: load on rd_en when idle, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_a <= '0;
         out_data_b <= '0;
      end else if (rd_en && !busy) begin
         out_data_a <= rd_a;
         out_data_b <= rd_b;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a 32-register and a 16-register
// instance share all stimulus; each read pushes both expected pairs.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs, rt, rd;
   logic        we, rd_en, clr_req;
   logic [31:0] i_data;
   logic [31:0] out_a, out_b, s_out_a, s_out_b;
   logic        busy, s_busy;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] a, b, sa, sb;
   } exp_t;

   exp_t sb_q[$];
   logic rd_fire = 1'b0;

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd), .we(we),
      .i_data(i_data), .rd_en(rd_en), .clr_req(clr_req),
      .out_data_a(out_a), .out_data_b(out_b), .busy(busy)
   );

   regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1)) u_small (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd), .we(we),
      .i_data(i_data), .rd_en(rd_en), .clr_req(clr_req),
      .out_data_a(s_out_a), .out_data_b(s_out_b), .busy(s_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: a read issued at a rising edge is checked at the next falling edge.
   always @(posedge clk) rd_fire <= rd_en && rst_n;

   always @(negedge clk) begin
      exp_t e;
      if (rd_fire) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty: got read response expected none");
         end else begin
            e = sb_q.pop_front();
            chk("out_a",   out_a,   e.a);
            chk("out_b",   out_b,   e.b);
            chk("s_out_a", s_out_a, e.sa);
            chk("s_out_b", s_out_b, e.sb);
         end
      end
   end

   // All drivers change at the falling edge.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rd = a; i_data = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rdq(input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] sa, input logic [31:0] sb);
      exp_t e;
      e.a = ea; e.b = eb; e.sa = sa; e.sb = sb;
      sb_q.push_back(e);
      rs = a; rt = b; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      int   nb, snb;
      exp_t e;
      logic [31:0] byp;
      rst_n = 1'b0; rs = '0; rt = '0; rd = '0; we = 1'b0; rd_en = 1'b0;
      clr_req = 1'b0; i_data = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_out_a", out_a, 32'h0);
      chk("rst_out_b", out_b, 32'h0);
      chk("rst_busy",  {31'b0, busy}, 32'h0);
      chk("rst_sbusy", {31'b0, s_busy}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      rdq(5'd3, 5'd4, 0, 0, 0, 0);
      wr(5'd5, 32'hDEADBEEF);
      rdq(5'd5, 5'd0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
      wr(5'd0, 32'h1234);
      rdq(5'd0, 5'd0, 0, 0, 0, 0);

      // Same-edge write and read of register 7.
      wr(5'd7, 32'h11);
`ifdef REGFILE_WRITE_BYPASS_EN
      byp = 32'hA5A5A5A5;
`else
      byp = 32'h11;
`endif
      e.a = byp; e.b = 32'hDEADBEEF; e.sa = byp; e.sb = 32'hDEADBEEF;
      sb_q.push_back(e);
      rd = 5'd7; i_data = 32'hA5A5A5A5; we = 1'b1;
      rs = 5'd7; rt = 5'd5; rd_en = 1'b1;
      @(negedge clk);
      we = 1'b0; rd_en = 1'b0;
      rdq(5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

      // Fill 1..31 with their index; the 16-entry copy drops 16..31.
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
      rdq(5'd20, 5'd31, 32'd20, 32'd31, 0, 0);
      rdq(5'd9, 5'd15, 32'd9, 32'd15, 32'd9, 32'd15);
      rdq(5'd5, 5'd6, 32'd5, 32'd6, 32'd5, 32'd6);

      // Bulk clear with ignored traffic in flight.
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      nb = 0; snb = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy)   nb++;
         if (s_busy) snb++;
         clr_req = (k == 3);
         if (k == 20) begin rd = 5'd9; i_data = 32'hFF; we = 1'b1; end
         if (k == 6) begin
            e.a = 32'd5; e.b = 32'd6; e.sa = 32'd5; e.sb = 32'd6;
            sb_q.push_back(e);
            rs = 5'd9; rt = 5'd10; rd_en = 1'b1;
         end
         @(negedge clk);
         clr_req = 1'b0; we = 1'b0; rd_en = 1'b0;
      end
      chk("busy_cycles",   32'(nb),  32'd32);
      chk("s_busy_cycles", 32'(snb), 32'd16);
      // The small copy was idle again when the reg-9 write arrived.
      for (int i = 0; i < 32; i++)
         rdq(5'(i), 5'(31 - i), 0, 0,
             (i == 9) ? 32'hFF : 32'h0, ((31 - i) == 9) ? 32'hFF : 32'h0);

      // Asynchronous reset in the middle of a clear.
      wr(5'd3, 32'h33);
      rdq(5'd3, 5'd3, 32'h33, 32'h33, 32'h33, 32'h33);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy",    {31'b0, busy},   32'h0);
      chk("arst_sbusy",   {31'b0, s_busy}, 32'h0);
      chk("arst_out_a",   out_a,   32'h0);
      chk("arst_out_b",   out_b,   32'h0);
      chk("arst_s_out_a", s_out_a, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_busy", {31'b0, busy}, 32'h0);
      rdq(5'd3, 5'd9, 0, 0, 0, 0);
      rdq(5'd31, 5'd15, 0, 0, 0, 0);
      @(negedge clk);

      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
